// File: rtl/mult_ctrl_pkg.sv
// Shared state encoding for the shift-and-add multiplier control FSM.
package mult_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_ADDSH = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mult_control.sv
// Control FSM for a sequential shift-and-add multiplier (Load, Add, Shift, Done).
// Optional debug port State[1:0] when MULT_CTRL_STATE_OUT_EN is defined.
module mult_control
    import mult_ctrl_pkg::*;
(
    input  logic Clk,
    input  logic Rst,
    input  logic St,
    input  logic M,
    input  logic K,
    output logic Idle,
    output logic Load,
    output logic Ad,
    output logic Sh,
    output logic Done
`ifdef MULT_CTRL_STATE_OUT_EN
    ,
    output logic [STATE_W-1:0] State
`endif
);

    state_t state;
    state_t state_nxt;

    // State register; reset wins over any in-flight operation.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef MULT_CTRL_STATE_OUT_EN
    assign State = STATE_W'(state);
`endif

    // Mealy next-state and output decode; reset forces the idle indication.
    always_comb begin
        state_nxt = S_IDLE;
        Idle      = 1'b0;
        Load      = 1'b0;
        Ad        = 1'b0;
        Sh        = 1'b0;
        Done      = 1'b0;

        if (Rst) begin
            Idle = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    Idle = 1'b1;
                    if (St) begin
                        Load      = 1'b1;
                        state_nxt = S_ADDSH;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
                S_ADDSH: begin
                    if (M) begin
                        Ad        = 1'b1;
                        state_nxt = S_SHIFT;
                    end else begin
                        Sh        = 1'b1;
                        state_nxt = K ? S_DONE : S_ADDSH;
                    end
                end
                S_SHIFT: begin
                    Sh        = 1'b1;
                    state_nxt = K ? S_DONE : S_ADDSH;
                end
                S_DONE: begin
                    Done      = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_control.sv
// Directed self-checking bench for mult_control; expected output vectors
// {Idle,Load,Ad,Sh,Done} are queued with each stimulus step and popped when sampled.
module tb_mult_control;

    typedef logic [4:0] ov_t;

    logic Clk;
    logic Rst;
    logic St;
    logic M;
    logic K;
    logic Idle;
    logic Load;
    logic Ad;
    logic Sh;
    logic Done;
`ifdef MULT_CTRL_STATE_OUT_EN
    logic [1:0] State;
`endif

    int unsigned tests_run;
    int unsigned tests_failed;

    ov_t   exp_q[$];
    string tag_q[$];

    mult_control dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .St   (St),
        .M    (M),
        .K    (K),
        .Idle (Idle),
        .Load (Load),
        .Ad   (Ad),
        .Sh   (Sh),
        .Done (Done)
`ifdef MULT_CTRL_STATE_OUT_EN
        ,
        .State(State)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Pop the oldest expectation and compare it with the current Mealy outputs.
    task automatic check_outputs();
        ov_t   obs;
        ov_t   exp_v;
        string tag;
        obs = {Idle, Load, Ad, Sh, Done};
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $error("FAIL scoreboard_empty: observed %b expected <queued value>", obs);
        end else begin
            exp_v = exp_q.pop_front();
            tag   = tag_q.pop_front();
            tests_run++;
            assert (obs === exp_v) else begin
                tests_failed++;
                $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
            end
            tests_run++;
            assert ((Ad & Sh) === 1'b0) else begin
                tests_failed++;
                $error("FAIL %s_ad_sh_excl: observed Ad=%b Sh=%b expected not both 1", tag, Ad, Sh);
            end
        end
    endtask

    // Apply one cycle of stimulus, check mid-cycle, then advance past the edge.
    task automatic step(input logic rst, input logic st, input logic m, input logic k,
                        input ov_t e, input string tag);
        Rst = rst;
        St  = st;
        M   = m;
        K   = k;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #2;
        check_outputs();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        Rst = 1'b1;
        St  = 1'b0;
        M   = 1'b0;
        K   = 1'b0;

        // 1: reset held two cycles, then idle
        step(1, 1, 1, 1, 5'b10000, "rst_cycle0");
        step(1, 0, 0, 0, 5'b10000, "rst_cycle1");
        step(0, 0, 1, 1, 5'b10000, "idle_after_rst0");
        step(0, 0, 0, 0, 5'b10000, "idle_after_rst1");

        // 2: full run with add, shift, last shift, done
        step(0, 1, 0, 0, 5'b11000, "run2_load");
        step(0, 0, 1, 0, 5'b00100, "run2_add");
        step(0, 0, 0, 0, 5'b00010, "run2_shift_k0");
        step(0, 0, 0, 1, 5'b00010, "run2_shift_last");
        step(0, 0, 0, 0, 5'b00001, "run2_done");
        step(0, 0, 0, 0, 5'b10000, "run2_idle");

        // 3: add path where the shift after add is the last one
        step(0, 1, 0, 0, 5'b11000, "run3_load");
        step(0, 0, 1, 0, 5'b00100, "run3_add");
        step(0, 0, 1, 1, 5'b00010, "run3_shift_last");
        step(0, 0, 0, 0, 5'b00001, "run3_done");
        step(0, 0, 1, 1, 5'b10000, "run3_done_one_cycle");

        // 4: St asserted mid-operation is ignored
        step(0, 1, 0, 0, 5'b11000, "run4_load");
        step(0, 1, 0, 0, 5'b00010, "run4_st_in_addsh");
        step(0, 1, 1, 0, 5'b00100, "run4_add");
        step(0, 1, 0, 0, 5'b00010, "run4_st_in_shift");
        step(0, 0, 0, 1, 5'b00010, "run4_shift_last");
        step(0, 0, 0, 0, 5'b00001, "run4_done");
        step(0, 0, 0, 0, 5'b10000, "run4_idle");

        // 5: reset while in S_SHIFT, then a fresh run
        step(0, 1, 0, 0, 5'b11000, "run5_load");
        step(0, 0, 1, 0, 5'b00100, "run5_add");
        step(1, 1, 1, 1, 5'b10000, "run5_rst_in_shift");
        step(0, 0, 1, 1, 5'b10000, "run5_idle_after_rst");
        step(0, 1, 0, 0, 5'b11000, "run5_reload");
        step(0, 0, 0, 1, 5'b00010, "run5_shift_last");
        step(0, 0, 0, 0, 5'b00001, "run5_done");
        step(0, 0, 0, 0, 5'b10000, "run5_idle");

        // 6: St held high gives back-to-back runs
        step(0, 1, 0, 0, 5'b11000, "run6_load_a");
        step(0, 1, 0, 0, 5'b00010, "run6_shift_a");
        step(0, 1, 0, 1, 5'b00010, "run6_shift_last_a");
        step(0, 1, 1, 1, 5'b00001, "run6_done_a");
        step(0, 1, 1, 1, 5'b11000, "run6_load_b");
        step(0, 1, 1, 1, 5'b00100, "run6_add_b");
        step(0, 1, 1, 1, 5'b00010, "run6_shift_last_b");
        step(0, 1, 0, 0, 5'b00001, "run6_done_b");
        step(0, 0, 0, 0, 5'b10000, "run6_idle");

        tests_run++;
        assert (exp_q.size() == 0) else begin
            tests_failed++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
